hazard_stall_controller: RTL

- Generates the pipeline-control signals consumed by the IF/ID register (IFIDWrite hold, FlushSignal), the PC register (PCWrite hold) and the ID/EX bubble insert.
- Handles three cases:
  - load-use hazards: single-cycle stall;
  - multi-cycle mult/div: counted stall;
  - taken-branch redirect: flush.
- Sits in the ID stage, alongside the IF/ID register it drives.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_controller.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//   ID-stage pipeline control. Decides, every cycle, whether the IF/ID and PC
//   registers hold, whether IF/ID is flushed, and whether a bubble goes into
//   ID/EX. Three sources of control:
//     - load-use hazard: one stall cycle while the load is in EX
//     - mult/div: MULDIV_STALL_CYCLES stall cycles after it enters EX
//     - taken branch: flush of IF/ID and bubble into ID/EX (highest priority)
//   A saturating counter records the number of stall cycles.
//
// Ports
//   Clk          rising-edge clock
//   Reset        synchronous, active-high
//   IDEXMemRead  EX instruction is a load
//   IDEXRegRt    destination register of the EX-stage load
//   IFIDRegRs    rs field of the ID instruction
//   IFIDRegRt    rt field of the ID instruction
//   IFIDUsesRt   ID instruction reads rt as a source
//   MulDivStart  ID instruction is a mult/div
//   BranchTaken  a branch resolved as taken this cycle
//   IFIDWrite    1 = IF/ID holds, 0 = IF/ID loads
//   PCWrite      1 = PC holds, 0 = PC updates
//   FlushSignal  1 = IF/ID clears at the next edge
//   IDEXFlush    1 = ID/EX loads a bubble
//   MulDivBusy   1 while a mult/div stall is in progress
//   StallCount   saturating count of stall cycles
module hazard_stall_controller #(
  parameter int MULDIV_STALL_CYCLES = 4,
  parameter int STALL_CNT_WIDTH     = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       IDEXMemRead,
  input  logic [4:0]                 IDEXRegRt,
  input  logic [4:0]                 IFIDRegRs,
  input  logic [4:0]                 IFIDRegRt,
  input  logic                       IFIDUsesRt,
  input  logic                       MulDivStart,
  input  logic                       BranchTaken,
  output logic                       IFIDWrite,
  output logic                       PCWrite,
  output logic                       FlushSignal,
  output logic                       IDEXFlush,
  output logic                       MulDivBusy,
  output logic [STALL_CNT_WIDTH-1:0] StallCount
);

  typedef enum logic {
    IDLE   = 1'b0,
    MULDIV = 1'b1
  } stateT;

  localparam logic [7:0] MulDivLoad = 8'(MULDIV_STALL_CYCLES);

  stateT      state;
  logic [7:0] remaining;
  logic       loadUse;
  logic       stallCycle;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [STALL_CNT_WIDTH-1:0] satInc(
    input logic [STALL_CNT_WIDTH-1:0] value
  );
    if (&value) return value;
    return value + STALL_CNT_WIDTH'(1);
  endfunction

  // Register 0 is hard-wired zero, so a load targeting it never creates a
  // dependency. rt only matters when the ID instruction actually reads it.
  always_comb begin
    loadUse = IDEXMemRead && (IDEXRegRt != 5'd0) &&
              ((IDEXRegRt == IFIDRegRs) ||
               (IFIDUsesRt && (IDEXRegRt == IFIDRegRt)));
  end

  // Outputs are combinational so the hold/flush takes effect in the same
  // cycle the condition is seen. A taken branch always wins: the ID
  // instruction is squashed, so any hazard it would have caused is moot.
  always_comb begin
    IFIDWrite   = 1'b0;
    PCWrite     = 1'b0;
    FlushSignal = 1'b0;
    IDEXFlush   = 1'b0;
    MulDivBusy  = 1'b0;
    stallCycle  = 1'b0;
    if (Reset) begin
      FlushSignal = 1'b1;
      IDEXFlush   = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (BranchTaken) begin
            FlushSignal = 1'b1;
            IDEXFlush   = 1'b1;
          end else if (loadUse) begin
            IFIDWrite  = 1'b1;
            PCWrite    = 1'b1;
            IDEXFlush  = 1'b1;
            stallCycle = 1'b1;
          end
        end
        MULDIV: begin
          MulDivBusy = 1'b1;
          if (BranchTaken) begin
            FlushSignal = 1'b1;
            IDEXFlush   = 1'b1;
          end else begin
            IFIDWrite  = 1'b1;
            PCWrite    = 1'b1;
            IDEXFlush  = 1'b1;
            stallCycle = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, remaining-cycle counter and performance counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      remaining  <= 8'd0;
      StallCount <= '0;
    end else begin
      if (stallCycle) StallCount <= satInc(StallCount);
      unique case (state)
        IDLE: begin
          // A load-use stall defers the mult/div; it is seen again next cycle.
          if (!BranchTaken && !loadUse && MulDivStart) begin
            state     <= MULDIV;
            remaining <= MulDivLoad;
          end
        end
        MULDIV: begin
          if (BranchTaken) begin
            state     <= IDLE;
            remaining <= 8'd0;
          end else begin
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          remaining <= 8'd0;
        end
      endcase
    end
  end

endmodule
